// File: rtl/coolrunner2_mc_regbank.sv
// Register column of one CoolRunner-II function block: D/T/bypass macrocell
// registers with product-term set/clear, clock enable, registered OE and a post-reset start-up hold.
module coolrunner2_mc_regbank #(
  parameter int          WIDTH          = 16,
  parameter logic [15:0] INIT           = 16'h0000,
  parameter int          REG_MODE       = 0,
  parameter int          STARTUP_CYCLES = 4,
  parameter int          FB_SEL         = 0
) (
  input  logic             C,
  input  logic             CLR_B,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] CE,
  input  logic [WIDTH-1:0] PRE,
  input  logic [WIDTH-1:0] CLR,
  input  logic [WIDTH-1:0] OE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] OE_Q,
  output logic [WIDTH-1:0] FB,
  output logic             READY
);

  localparam int              CW        = (STARTUP_CYCLES < 2) ? 1 : $clog2(STARTUP_CYCLES + 1);
  localparam logic [CW-1:0]   LAST      = CW'((STARTUP_CYCLES == 0) ? 0 : STARTUP_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT_W   = INIT[WIDTH-1:0];
  localparam bit              START_RUN = (STARTUP_CYCLES == 0);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_eff;
  logic [WIDTH-1:0] q_next;

  // Clear beats preset, both beat the clock enable; bits never interact.
  always_comb begin
    d_eff  = (REG_MODE == 1) ? (q_reg ^ D) : D;
    q_next = (q_reg & ~CE) | (d_eff & CE);
    q_next = (q_next | PRE) & ~CLR;
  end

  always_ff @(posedge C or negedge CLR_B) begin
    if (!CLR_B) begin
      state <= START_RUN ? RUN : HOLD;
      cnt   <= '0;
      READY <= START_RUN;
      OE_Q  <= '0;
      q_reg <= INIT_W;
    end else begin
      case (state)
        HOLD: begin
          OE_Q <= '0;
          if (cnt == LAST) begin
            state <= RUN;
            READY <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          OE_Q <= OE;
          if (REG_MODE != 2) q_reg <= q_next;
        end
        default: state <= HOLD;
      endcase
    end
  end

  // Bypass mode passes D straight through once running, INIT while holding.
  assign Q  = (REG_MODE == 2) ? ((state == RUN) ? D : INIT_W) : q_reg;
  assign FB = (FB_SEL == 1) ? D : Q;

endmodule
